mlp_sequencer: RTL and testbench

//  Control FSM that time-shares one MAC/activation datapath across the hidden and

---
 rtl/mlp_pkg.sv | 31 +++
 rtl/mlp_argmax.sv | 51 +++++
 rtl/mlp_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mlp_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_RES,
        S_DONE
    } state_e;

    localparam int N_IN_DEF        = 62;
    localparam int N_HID_DEF       = 30;
    localparam int N_OUT_DEF       = 10;
    localparam int NUM_SAMPLES_DEF = 750;
    localparam int SCORE_W_DEF     = 16;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

    localparam int L2_W_BASE = N_IN_DEF * N_HID_DEF;

    function automatic int cw(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Running signed maximum over the output-layer scores of one sample.
import mlp_pkg::*;

module mlp_argmax #(
    parameter int SCORE_W = 16,
    parameter int IW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               valid_i,
    input  logic               first_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [IW-1:0]      idx_i,
    output logic [IW-1:0]      best_idx_o
);

    localparam logic [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      take;

    // First score of a sample always replaces the running best
    assign take = valid_i && (first_i || ($signed(score_i) > best_q));

    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        if (clr_i) begin
            best_d = MOST_NEG;
            idx_d  = '0;
        end else if (take) begin
            best_d = score_i;
            idx_d  = idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= MOST_NEG;
            idx_q  <= '0;
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign best_idx_o = idx_q;

endmodule

// File: rtl/mlp_sequencer.sv
// Two-layer MLP control FSM: address/MAC sequencing plus per-sample argmax.
// Optional abort input enabled by defining MLP_SEQ_ABORT_EN.
import mlp_pkg::*;

module mlp_sequencer #(
    parameter int N_IN        = N_IN_DEF,
    parameter int N_HID       = N_HID_DEF,
    parameter int N_OUT       = N_OUT_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int SCORE_W     = SCORE_W_DEF,
    localparam int SW = cw(NUM_SAMPLES),
    localparam int KW = cw(max2(N_IN, N_HID)),
    localparam int WW = cw(N_IN * N_HID + N_HID * N_OUT),
    localparam int NW = cw(max2(N_HID, N_OUT)),
    localparam int RW = cw(N_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef MLP_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic [SW-1:0]      sample_idx,
    output logic [KW-1:0]      in_addr,
    output logic [WW-1:0]      w_addr,
    output logic [NW-1:0]      neuron_idx,
    output logic               layer_sel,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               act_we,
    input  logic [SCORE_W-1:0] score,
    output logic [RW-1:0]      result,
    output logic               result_valid,
    output logic               batch_done
);

    localparam logic [KW-1:0] K1_LAST = KW'(N_IN - 1);
    localparam logic [KW-1:0] K2_LAST = KW'(N_HID - 1);
    localparam logic [NW-1:0] N1_LAST = NW'(N_HID - 1);
    localparam logic [NW-1:0] N2_LAST = NW'(N_OUT - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(NUM_SAMPLES - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [NW-1:0] n_q, n_d;
    logic [WW-1:0] w_q, w_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [RW-1:0] res_q, res_d;
    logic          wr_q, wr_d;
    logic          abort_w;
    logic          clr;
    logic [NW-1:0] best_idx;

`ifdef MLP_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        w_d          = w_q;
        smp_d        = smp_q;
        res_d        = res_q;
        wr_d         = wr_q;
        clr          = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        act_we       = 1'b0;
        layer_sel    = LAYER_HID;
        result_valid = 1'b0;
        batch_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_L1;
                    clr     = 1'b1;
                end
            end
            S_L1: begin
                if (!wr_q) begin
                    mac_en  = 1'b1;
                    mac_clr = (k_q == '0);
                    w_d     = w_q + WW'(1);
                    wr_d    = (k_q == K1_LAST);
                    k_d     = (k_q == K1_LAST) ? '0 : k_q + KW'(1);
                end else begin
                    act_we = 1'b1;
                    wr_d   = 1'b0;
                    n_d    = (n_q == N1_LAST) ? '0 : n_q + NW'(1);
                    if (n_q == N1_LAST) state_d = S_L2;
                end
            end
            S_L2: begin
                layer_sel = LAYER_OUT;
                if (!wr_q) begin
                    mac_en  = 1'b1;
                    mac_clr = (k_q == '0);
                    w_d     = w_q + WW'(1);
                    wr_d    = (k_q == K2_LAST);
                    k_d     = (k_q == K2_LAST) ? '0 : k_q + KW'(1);
                end else begin
                    act_we = 1'b1;
                    wr_d   = 1'b0;
                    n_d    = (n_q == N2_LAST) ? '0 : n_q + NW'(1);
                    if (n_q == N2_LAST) state_d = S_RES;
                end
            end
            S_RES: begin
                result_valid = 1'b1;
                res_d        = best_idx[RW-1:0];
                w_d          = '0;
                if (smp_q == S_LAST) begin
                    state_d = S_DONE;
                end else begin
                    smp_d   = smp_q + SW'(1);
                    state_d = S_L1;
                end
            end
            S_DONE: begin
                batch_done = 1'b1;
                smp_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort discards the sample in flight; the last result is kept
        if (abort_w && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            k_d          = '0;
            n_d          = '0;
            w_d          = '0;
            smp_d        = '0;
            wr_d         = 1'b0;
            res_d        = res_q;
            result_valid = 1'b0;
            batch_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
            smp_q   <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            w_q     <= w_d;
            smp_q   <= smp_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
        end
    end

    mlp_argmax #(
        .SCORE_W (SCORE_W),
        .IW      (NW)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .valid_i    (act_we && state_q == S_L2),
        .first_i    (n_q == '0),
        .score_i    (score),
        .idx_i      (n_q),
        .best_idx_o (best_idx)
    );

    assign busy       = (state_q != S_IDLE);
    assign sample_idx = smp_q;
    assign in_addr    = k_q;
    assign w_addr     = w_q;
    assign neuron_idx = n_q;
    assign result     = result_valid ? best_idx[RW-1:0] : res_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer with a 4-3-2 network and 2-sample batches.
module tb_mlp_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic [0:0]  sample_idx;
    logic [1:0]  in_addr;
    logic [4:0]  w_addr;
    logic [1:0]  neuron_idx;
    logic        layer_sel;
    logic        mac_clr;
    logic        mac_en;
    logic        act_we;
    logic [15:0] score;
    logic [0:0]  result;
    logic        result_valid;
    logic        batch_done;

    logic signed [15:0] sc [0:1][0:3];

    int n_cmp = 0;
    int n_mis = 0;

    mlp_sequencer #(
        .N_IN        (4),
        .N_HID       (3),
        .N_OUT       (2),
        .NUM_SAMPLES (2),
        .SCORE_W     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef MLP_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .sample_idx   (sample_idx),
        .in_addr      (in_addr),
        .w_addr       (w_addr),
        .neuron_idx   (neuron_idx),
        .layer_sel    (layer_sel),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .act_we       (act_we),
        .score        (score),
        .result       (result),
        .result_valid (result_valid),
        .batch_done   (batch_done)
    );

    assign score = sc[sample_idx][neuron_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({busy, sample_idx, in_addr, w_addr, neuron_idx, layer_sel,
                    mac_clr, mac_en, act_we, result, result_valid,
                    batch_done});
    endfunction

    // cut_at < 0: full batch; otherwise abort or reset is applied at cycle cut_at
    task automatic run_batch(input logic er0, input logic er1,
                             input int cut_at, input bit use_abort);
        int  rv_cnt;
        int  bd_cnt;
        bit  live;
        rv_cnt = 0;
        bd_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 56; t++) begin
            live = (cut_at < 0) || (t < cut_at);
            if (t == 0) begin
                chk("busy_at_start", busy, 1);
                chk("clr_k0", {mac_en, mac_clr}, 2'b11);
                chk("waddr_k0", w_addr, 0);
            end
            if (t == 3) chk("k3", {mac_clr, in_addr, w_addr}, {1'b0, 2'd3, 5'd3});
            if (t == 4) chk("l1_write", {act_we, mac_en, neuron_idx}, {1'b1, 1'b0, 2'd0});
            if (t == 5) chk("n1_k0", {mac_clr, in_addr, w_addr, neuron_idx},
                            {1'b1, 2'd0, 5'd4, 2'd1});
            if (live && t == 15) chk("l2_start", {layer_sel, mac_clr, w_addr, neuron_idx},
                                     {1'b1, 1'b1, 5'd12, 2'd0});
            if (live && t == 19) chk("l2_m1", {w_addr, neuron_idx}, {5'd15, 2'd1});
            if (live && t == 23) chk("res0", {result_valid, result, sample_idx},
                                     {1'b1, er0, 1'b0});
            if (live && t == 24) chk("hold0", {result_valid, result, sample_idx},
                                     {1'b0, er0, 1'b1});
            if (live && t == 47) chk("res1", {result_valid, result}, {1'b1, er1});
            if (live && t == 48) chk("done48", {batch_done, busy}, 2'b11);
            if (live && t == 49) chk("idle49", {busy, batch_done}, 2'b00);
            if (use_abort && t == cut_at + 1)
                chk("abort_idle", {busy, mac_en, result_valid}, 3'b000);
            rv_cnt += int'(result_valid);
            bd_cnt += int'(batch_done);
            start = live && (t == 10 || t == 30);
            if (t == cut_at) begin
                if (use_abort) begin
                    abort = 1'b1;
                end else begin
                    rst_n = 1'b0;
                    #1;
                    chk("async_rst_zero", all_out(), 0);
                    break;
                end
            end
            @(posedge clk); #1;
            abort = 1'b0;
        end
        start = 1'b0;
        chk("rv_count", rv_cnt, (cut_at < 0) ? 2 : (use_abort ? 0 : 1));
        chk("bd_count", bd_cnt, (cut_at < 0) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < 4; n++)
                sc[s][n] = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", all_out(), 0);

        sc[0][0] = -16'sd5; sc[0][1] = 16'sd7;
        sc[1][0] = 16'sd3;  sc[1][1] = 16'sd3;
        run_batch(1'b1, 1'b0, -1, 1'b0);

        sc[1][0] = -16'sd1; sc[1][1] = 16'sd9;
        run_batch(1'b1, 1'b1, 30, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_in_reset", all_out(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_batch(1'b1, 1'b1, -1, 1'b0);

`ifdef MLP_SEQ_ABORT_EN
        run_batch(1'b1, 1'b1, 16, 1'b1);
        chk("abort_keeps_result", {busy, result}, {1'b0, 1'b1});
        run_batch(1'b1, 1'b1, -1, 1'b0);
`endif

        sc[0][0] = 16'sh8000; sc[0][1] = 16'sh8000;
        sc[1][0] = 16'sh8000; sc[1][1] = 16'sh8000;
        run_batch(1'b0, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
